// File: rtl/axi4_burst_ctrl.sv
// Turns one command into one AXI4 INCR burst (4-byte beats); AxVALID one cycle after accept.
// W beats follow wr_valid/WREADY, R never stalls, done pulses one cycle with the worst-case response.
module axi4_burst_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  localparam int CW = ADDR_WIDTH + 11;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [1:0]            resp_q;
  logic [1:0]            rresp_max;
  logic [CW-1:0]         end_addr;
  logic                  cmd_bad;
  logic                  accept;
  logic                  w_last_hs;

  // End address is computed wide so a burst running past the top cannot wrap back in range.
  assign end_addr  = CW'(cmd_addr) + ((CW'(cmd_len) + CW'(1)) << 2);
  assign cmd_bad   = (cmd_addr[1:0] != 2'b00) || (end_addr > (CW'(1) << ADDR_WIDTH));
  assign accept    = (state == S_IDLE) && cmd_valid;
  assign w_last_hs = (state == S_W) && wr_valid && WREADY && (cnt_q == len_q);
  assign rresp_max = (RRESP > resp_q) ? RRESP : resp_q;

  assign AWADDR = addr_q;
  assign ARADDR = addr_q;
  assign AWLEN  = len_q;
  assign ARLEN  = len_q;
  assign WDATA  = wr_data;
  assign rd_data = RDATA;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    AWVALID   = 1'b0;
    ARVALID   = 1'b0;
    WVALID    = 1'b0;
    WLAST     = 1'b0;
    wr_ready  = 1'b0;
    BREADY    = 1'b0;
    RREADY    = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    done      = 1'b0;
    done_resp = 2'b00;
    case (state)
      S_IDLE: begin
        cmd_ready = ARESETn;
        if (cmd_valid) state_nxt = cmd_bad ? S_DONE : (cmd_write ? S_AW : S_AR);
      end
      S_AW: begin
        AWVALID = 1'b1;
        if (AWREADY) state_nxt = S_W;
      end
      S_W: begin
        WVALID   = wr_valid;
        wr_ready = WREADY;
        WLAST    = (cnt_q == len_q);
        if (w_last_hs) state_nxt = S_B;
      end
      S_B: begin
        BREADY = 1'b1;
        if (BVALID) state_nxt = S_DONE;
      end
      S_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nxt = S_R;
      end
      S_R: begin
        RREADY   = 1'b1;
        rd_valid = RVALID;
        rd_last  = RLAST;
        if (RVALID && RLAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        done_resp = resp_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      resp_q <= 2'b00;
    end else begin
      if (accept) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        cnt_q  <= '0;
        resp_q <= cmd_bad ? 2'b10 : 2'b00;
      end
      if ((state == S_W) && wr_valid && WREADY) cnt_q <= cnt_q + 8'd1;
      if ((state == S_B) && BVALID) resp_q <= BRESP;
      if ((state == S_R) && RVALID) begin
        cnt_q <= cnt_q + 8'd1;
        // A burst cut short or overrun by the slave's RLAST is reported as an error.
        resp_q <= (RLAST && (cnt_q != len_q)) ? 2'b10 : rresp_max;
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_ctrl.sv
// Directed bench for axi4_burst_ctrl: the bench acts as command source and AXI slave.
module tb_axi4_burst_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_valid, wr_ready, rd_valid, rd_last, done;
  logic [1:0]    done_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic          AWVALID, AWREADY, ARVALID, ARREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic          WLAST, WVALID, WREADY, BVALID, BREADY, RLAST, RVALID, RREADY;
  logic [1:0]    BRESP, RRESP;

  int vectors = 0;
  int miscompares = 0;

  always #5 ACLK = ~ACLK;

  axi4_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .done(done), .done_resp(done_resp),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic slave_idle();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
    ARREADY = 0; RDATA = '0; RRESP = 2'b00; RLAST = 0; RVALID = 0;
  endtask

  task automatic test_reset();
    slave_idle();
    ARESETn = 0;
    #1;
    vectors++;
    if ({cmd_ready, AWVALID, ARVALID, WVALID, wr_ready, BREADY, RREADY, done, WLAST} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 000000000",
               {cmd_ready, AWVALID, ARVALID, WVALID, wr_ready, BREADY, RREADY, done, WLAST});
    end
    vectors++;
    if ({AWADDR, ARADDR, AWLEN, ARLEN, done_resp} !== '0) begin
      miscompares++;
      $display("FAIL reset_addr: got AWADDR=%h ARADDR=%h AWLEN=%h ARLEN=%h resp=%b expected all 0",
               AWADDR, ARADDR, AWLEN, ARLEN, done_resp);
    end
    @(negedge ACLK); @(negedge ACLK);
    ARESETn = 1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len,
                          input int aw_delay, input bit toggle, input logic [1:0] bresp);
    int beats = 0, aw_seen = 0, aw_hs = 0;
    bit aw_done = 0, finished = 0;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = 1; cmd_addr = addr; cmd_len = len;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1 || AWVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_accept: got ready=%b awvalid=%b expected 1/0", cmd_ready, AWVALID);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      cmd_valid = 0;
      AWREADY  = (aw_seen >= aw_delay);
      WREADY   = 1;
      wr_valid = toggle ? (i % 2 == 1) : 1'b1;
      wr_data  = 32'hA0 + beats;
      BVALID   = 1; BRESP = bresp;
      #1;
      if (done) begin finished = 1; break; end
      if (i == 0) begin
        vectors++;
        if (AWVALID !== 1'b1) begin
          miscompares++;
          $display("FAIL wr_aw_latency: got AWVALID=%b expected 1", AWVALID);
        end
      end
      if (aw_seen > 0 && !aw_done) begin
        vectors++;
        if (AWVALID !== 1'b1) begin
          miscompares++;
          $display("FAIL wr_aw_hold: got AWVALID=%b expected 1", AWVALID);
        end
      end
      if (!aw_done && WVALID) begin
        miscompares++; vectors++;
        $display("FAIL wr_w_early: got WVALID=1 before AW handshake expected 0");
      end
      if (AWVALID) begin
        vectors++;
        if (AWADDR !== addr || AWLEN !== len) begin
          miscompares++;
          $display("FAIL wr_aw_stable: got addr=%h len=%h expected %h/%h", AWADDR, AWLEN, addr, len);
        end
        aw_seen++;
        if (AWREADY) begin aw_done = 1; aw_hs++; end
      end
      if (WVALID && wr_ready) begin
        vectors++;
        if (WDATA !== 32'hA0 + beats || WLAST !== (beats == int'(len))) begin
          miscompares++;
          $display("FAIL wr_beat%0d: got data=%h last=%b expected %h/%b",
                   beats, WDATA, WLAST, 32'hA0 + beats, (beats == int'(len)));
        end
        beats++;
      end
    end
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL wr_timeout: got no done in 100 cycles expected done");
    end
    vectors++;
    if (beats != int'(len) + 1 || aw_hs != 1) begin
      miscompares++;
      $display("FAIL wr_counts: got beats=%0d aw_hs=%0d expected %0d/1", beats, aw_hs, int'(len) + 1);
    end
    vectors++;
    if (done_resp !== bresp || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_resp: got resp=%b ready=%b expected %b/0", done_resp, cmd_ready, bresp);
    end
    @(negedge ACLK);
    slave_idle();
    #1;
    vectors++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_after_done: got done=%b ready=%b expected 0/1", done, cmd_ready);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input int rlast_at,
                         input logic [15:0] rresp, input int exp_beats, input logic [1:0] exp_resp);
    int beats = 0;
    bit finished = 0;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = 0; cmd_addr = addr; cmd_len = len;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1 || ARVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_accept: got ready=%b arvalid=%b expected 1/0", cmd_ready, ARVALID);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      cmd_valid = 0;
      ARREADY = 1;
      RVALID  = 1;
      RDATA   = 32'hD000_0000 + beats;
      RRESP   = rresp[2*beats +: 2];
      RLAST   = (beats == rlast_at);
      #1;
      if (done) begin finished = 1; break; end
      if (i == 0) begin
        vectors++;
        if (ARVALID !== 1'b1 || ARADDR !== addr || ARLEN !== len || AWVALID !== 1'b0) begin
          miscompares++;
          $display("FAIL rd_ar: got arvalid=%b addr=%h len=%h awvalid=%b expected 1/%h/%h/0",
                   ARVALID, ARADDR, ARLEN, AWVALID, addr, len);
        end
      end
      if (RREADY) begin
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hD000_0000 + beats || rd_last !== (beats == rlast_at)) begin
          miscompares++;
          $display("FAIL rd_beat%0d: got vld=%b data=%h last=%b expected 1/%h/%b",
                   beats, rd_valid, rd_data, rd_last, 32'hD000_0000 + beats, (beats == rlast_at));
        end
        beats++;
      end else if (rd_valid !== 1'b0) begin
        miscompares++; vectors++;
        $display("FAIL rd_vld_gate: got rd_valid=%b outside R expected 0", rd_valid);
      end
    end
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL rd_timeout: got no done in 100 cycles expected done");
    end
    vectors++;
    if (beats != exp_beats || done_resp !== exp_resp) begin
      miscompares++;
      $display("FAIL rd_result: got beats=%0d resp=%b expected %0d/%b", beats, done_resp, exp_beats, exp_resp);
    end
    @(negedge ACLK);
    slave_idle();
    #1;
    vectors++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_after_done: got done=%b ready=%b expected 0/1", done, cmd_ready);
    end
  endtask

  task automatic do_reject(input logic wr, input logic [AW-1:0] addr, input logic [7:0] len);
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    AWREADY = 1; ARREADY = 1;
    #1;
    @(negedge ACLK);
    cmd_valid = 0;
    #1;
    vectors++;
    if (done !== 1'b1 || done_resp !== 2'b10 || AWVALID !== 1'b0 || ARVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL reject_%h: got done=%b resp=%b aw=%b ar=%b expected 1/10/0/0",
               addr, done, done_resp, AWVALID, ARVALID);
    end
    @(negedge ACLK);
    #1;
    vectors++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || AWVALID !== 1'b0 || ARVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL reject_after_%h: got done=%b ready=%b aw=%b ar=%b expected 0/1/0/0",
               addr, done, cmd_ready, AWVALID, ARVALID);
    end
    slave_idle();
  endtask

  task automatic test_reset_mid_burst();
    int hs = 0;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 10'h040; cmd_len = 8'd7;
    for (int i = 0; i < 20 && hs < 1; i++) begin
      @(negedge ACLK);
      cmd_valid = 0; AWREADY = 1; WREADY = 1; wr_valid = 1; wr_data = 32'h55;
      #1;
      if (WVALID && wr_ready) hs++;
    end
    vectors++;
    if (hs != 1) begin
      miscompares++;
      $display("FAIL rst_setup: got %0d W handshakes expected 1", hs);
    end
    @(negedge ACLK);
    ARESETn = 0;
    #1;
    vectors++;
    if ({AWVALID, WVALID, wr_ready, BREADY, ARVALID, RREADY, done, cmd_ready} !== 8'b0) begin
      miscompares++;
      $display("FAIL rst_mid_valids: got %b expected 00000000",
               {AWVALID, WVALID, wr_ready, BREADY, ARVALID, RREADY, done, cmd_ready});
    end
    slave_idle();
    @(negedge ACLK);
    ARESETn = 1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || AWADDR !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_release: got ready=%b done=%b awaddr=%h expected 1/0/000", cmd_ready, done, AWADDR);
    end
    do_read(10'h100, 8'd0, 0, 16'h0000, 1, 2'b00);
  endtask

  initial begin
    test_reset();
    do_write(10'h010, 8'd3, 0, 1'b0, 2'b00);
    do_read(10'h3F0, 8'd3, 3, 16'h0020, 4, 2'b10);
    do_reject(1'b1, 10'h3F8, 8'd3);
    do_reject(1'b0, 10'h011, 8'd0);
    do_write(10'h020, 8'd3, 5, 1'b1, 2'b00);
    do_read(10'h080, 8'd3, 1, 16'h0000, 2, 2'b10);
    do_write(10'h0C0, 8'd1, 0, 1'b0, 2'b10);
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axi4_burst_ctrl.md
Name: axi4_burst_ctrl

Overview:
- AXI4 master-side sequencer that turns single-command requests into one INCR burst on the AXI4 memory-mapped slave.
- Sits between the test or system command source and the slave; its bus traffic is what the bus monitor logs.
- Runs one transaction at a time, checks the command against the address range, and reports completion with a single response code.

Parameters:
DATA_WIDTH, 32, data bus width; beat size fixed at 4 bytes
ADDR_WIDTH, 10, byte-address width; memory spans 2^ADDR_WIDTH bytes

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when both high
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_WIDTH  start byte address
cmd_len  in  8  beats minus one (AxLEN)
wr_data  in  DATA_WIDTH  write beat data
wr_valid  in  1  write beat available
wr_ready  out  1  write beat consumed when both high
rd_data  out  DATA_WIDTH  read beat data
rd_valid  out  1  read beat strobe
rd_last  out  1  final read beat
done  out  1  one-cycle completion pulse
done_resp  out  2  completion response (OKAY=00, SLVERR=10)
AWADDR/AWLEN/AWVALID  out  ADDR_WIDTH/8/1  write address channel
AWREADY  in  1  write address ready
WDATA/WLAST/WVALID  out  DATA_WIDTH/1/1  write data channel
WREADY  in  1  write data ready
BRESP/BVALID  in  2/1  write response
BREADY  out  1  write response ready
ARADDR/ARLEN/ARVALID  out  ADDR_WIDTH/8/1  read address channel
ARREADY  in  1  read address ready
RDATA/RRESP/RLAST/RVALID  in  DATA_WIDTH/2/1/1  read data channel
RREADY  out  1  read data ready

Behaviour:
- Reset (async, ARESETn=0):
  - State goes to IDLE.
  - All VALID/READY outputs, done, done_resp, WLAST and the beat counter are 0.
  - AWADDR, ARADDR, AWLEN and ARLEN are 0.
  - Reset mid-burst abandons the transaction at once. No done pulse is produced.
- Fixed bus attributes: AxSIZE = 4 bytes, AxBURST = INCR, full strobes. These are not driven as ports.
- States: IDLE, AW, W, B, AR, R, DONE.
- IDLE:
  - cmd_ready=1 here only.
  - On cmd_valid, latch write, addr and len.
  - Reject the command if either holds:
    - cmd_addr[1:0]!=0.
    - cmd_addr + (cmd_len+1)*4 > 2^ADDR_WIDTH. Compute at ADDR_WIDTH+11 bits, with no wrap-around.
  - Reject path: go to DONE with resp=10. No bus activity.
  - Otherwise go to AW if cmd_write=1, else AR.
- AW / AR:
  - AxVALID rises the cycle after acceptance (latency 1).
  - AxVALID is held, with address and len stable, until AxREADY.
  - On the handshake, go to W or R respectively.
- W:
  - WVALID = wr_valid, wr_ready = WREADY, WDATA = wr_data. These are combinational pass-through, gated by state.
  - The beat counter increments on each W handshake.
  - WLAST = (count == len).
  - The last handshake goes to B. W never starts before the AW handshake.
- B:
  - BREADY=1.
  - On BVALID, latch BRESP into the response, then go to DONE.
- R:
  - RREADY=1, with no backpressure.
  - rd_valid = RVALID, rd_data = RDATA, rd_last = RLAST.
  - The response accumulates as the worst case, i.e. the maximum RRESP over the beats.
  - The burst ends on the beat with RLAST. If the beat count at RLAST is not len, force the response to 10.
  - Go to DONE.
- DONE:
  - done=1 and done_resp = latched response, for exactly one cycle. cmd_ready=0.
  - Next state is IDLE.
  - Minimum spacing between consecutive accepted commands is therefore one DONE cycle plus one IDLE cycle.
- Simultaneous events:
  - An AxREADY that is already high when AxVALID rises completes the handshake in that cycle.
  - A B/R response arriving in the same cycle the state is entered is accepted in that cycle.

Test Plan:
- Write addr=0x010, len=3, data 0xA0..0xA3, slave ready always -> AWVALID 1 cycle after accept; 4 W beats with WLAST on the 4th; done=1, done_resp=00.
- Read addr=0x3F0, len=3, RRESP=00,00,10,00 -> 4 rd_valid beats, rd_last on the 4th; done_resp=10.
- Command addr=0x3F8, len=3 (ends at 0x408) and addr=0x011 -> no AWVALID/ARVALID; done 1 cycle after accept with resp=10.
- Write with AWREADY delayed 5 cycles and wr_valid toggling every other cycle -> AWADDR/AWLEN stable while AWVALID=1; exactly 4 W handshakes; WLAST only on the last beat.
- Read with len=3 but slave asserts RLAST on the 2nd beat -> transaction ends after 2 beats; done_resp=10; next command accepted normally.
- ARESETn pulsed low during W beat 2 of a len=7 write -> all valids 0 immediately, no done pulse; cmd_ready=1 after release; a new read of len=0 completes with resp=00.
